// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS BCD stopwatch core with run/pause and manual adjust mode
module stopwatch_counter #(
  parameter int MAX_MIN = 59
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       clk_2hz,
  input  logic       btn_pause,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       paused,
  output logic       blink
);
  localparam logic [3:0] MT = 4'(MAX_MIN / 10);
  localparam logic [3:0] MO = 4'(MAX_MIN % 10);
  typedef enum logic [1:0] {PAUSED, RUN, ADJUST} state_t;
  state_t state, state_nx;
  logic prev_1hz, prev_2hz, prev_btn;
  logic tick_1hz, tick_2hz, press;
  logic run_flag, run_nx, blink_nx;
  logic inc_sec, inc_min, sec_wrap, min_wrap;
  logic [3:0] min_tens_nx, min_ones_nx, sec_tens_nx, sec_ones_nx;
  assign tick_1hz = clk_1hz & ~prev_1hz;
  assign tick_2hz = clk_2hz & ~prev_2hz;
  assign press    = btn_pause & ~prev_btn;
  assign paused   = ~run_flag;
  always_comb begin
    state_nx = state;
    run_nx   = run_flag;
    if (state == ADJUST) state_nx = adj ? ADJUST : (run_flag ? RUN : PAUSED);
    else if (adj) state_nx = ADJUST;
    else if (press) begin
      run_nx   = ~run_flag;
      state_nx = run_flag ? PAUSED : RUN;
    end
    // blink only advances while already in ADJUST and drops to 0 as soon as we leave
    blink_nx = (state_nx == ADJUST) ? blink ^ (tick_2hz && state == ADJUST) : 1'b0;
  end
  always_comb begin
    sec_wrap    = sec_tens == 4'd5 && sec_ones == 4'd9;
    min_wrap    = min_tens == MT && min_ones == MO;
    inc_sec     = (state == RUN && tick_1hz) || (state == ADJUST && tick_2hz && sel);
    inc_min     = (state == RUN && tick_1hz && sec_wrap) || (state == ADJUST && tick_2hz && !sel);
    sec_ones_nx = !inc_sec ? sec_ones : (sec_ones == 4'd9 ? 4'd0 : sec_ones + 4'd1);
    sec_tens_nx = !inc_sec || sec_ones != 4'd9 ? sec_tens : (sec_tens == 4'd5 ? 4'd0 : sec_tens + 4'd1);
    min_ones_nx = !inc_min ? min_ones : (min_wrap || min_ones == 4'd9 ? 4'd0 : min_ones + 4'd1);
    min_tens_nx = !inc_min ? min_tens : (min_wrap ? 4'd0 : (min_ones == 4'd9 ? min_tens + 4'd1 : min_tens));
  end
  always_ff @(posedge sclk) begin
    if (rst) begin
      state    <= PAUSED;
      run_flag <= 1'b0;
      blink    <= 1'b0;
      prev_1hz <= 1'b1;
      prev_2hz <= 1'b1;
      prev_btn <= 1'b1;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else begin
      state    <= state_nx;
      run_flag <= run_nx;
      blink    <= blink_nx;
      prev_1hz <= clk_1hz;
      prev_2hz <= clk_2hz;
      prev_btn <= btn_pause;
      min_tens <= min_tens_nx;
      min_ones <= min_ones_nx;
      sec_tens <= sec_tens_nx;
      sec_ones <= sec_ones_nx;
    end
  end
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed scenario tests for stopwatch_counter
module tb_stopwatch_counter;
  logic sclk = 1'b0, rst = 1'b1, clk_1hz = 1'b0, clk_2hz = 1'b0, btn_pause = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic paused, blink;
  logic [15:0] disp;
  int total = 0, bad = 0;
  stopwatch_counter dut (
    .sclk(sclk), .rst(rst), .clk_1hz(clk_1hz), .clk_2hz(clk_2hz), .btn_pause(btn_pause),
    .adj(adj), .sel(sel), .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .paused(paused), .blink(blink)
  );
  assign disp = {min_tens, min_ones, sec_tens, sec_ones};
  always #5 sclk = ~sclk;
  task automatic step(int n);
    repeat (n) @(negedge sclk);
  endtask
  task automatic tick1();
    clk_1hz = 1'b1;
    step(2);
    clk_1hz = 1'b0;
    step(2);
  endtask
  task automatic tick2();
    clk_2hz = 1'b1;
    step(2);
    clk_2hz = 1'b0;
    step(2);
  endtask
  task automatic push(int hold);
    btn_pause = 1'b1;
    step(hold);
    btn_pause = 1'b0;
    step(1);
  endtask
  task automatic test_reset();
    rst = 1'b1; btn_pause = 1'b0; adj = 1'b0; sel = 1'b0; clk_1hz = 1'b0; clk_2hz = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    total++; if (disp !== 16'h0000) begin bad++; $display("FAIL reset_disp got=%h exp=0000", disp); end
    total++; if (paused !== 1'b1) begin bad++; $display("FAIL reset_paused got=%b exp=1", paused); end
    total++; if (blink !== 1'b0) begin bad++; $display("FAIL reset_blink got=%b exp=0", blink); end
  endtask
  task automatic test_count();
    test_reset();
    push(2);
    total++; if (paused !== 1'b0) begin bad++; $display("FAIL count_run got=%b exp=0", paused); end
    for (int i = 0; i < 74; i++) tick1();
    total++; if (disp !== 16'h0114) begin bad++; $display("FAIL count_74 got=%h exp=0114", disp); end
    clk_1hz = 1'b1;
    #1;
    total++; if (disp !== 16'h0114) begin bad++; $display("FAIL count_latency0 got=%h exp=0114", disp); end
    step(1);
    total++; if (disp !== 16'h0115) begin bad++; $display("FAIL count_75 got=%h exp=0115", disp); end
    step(3);
    clk_1hz = 1'b0;
    step(2);
    total++; if (disp !== 16'h0115) begin bad++; $display("FAIL count_hold got=%h exp=0115", disp); end
  endtask
  task automatic test_wrap();
    test_reset();
    adj = 1'b1; sel = 1'b1;
    step(1);
    for (int i = 0; i < 59; i++) tick2();
    sel = 1'b0;
    for (int i = 0; i < 59; i++) tick2();
    total++; if (disp !== 16'h5959) begin bad++; $display("FAIL wrap_preload got=%h exp=5959", disp); end
    adj = 1'b0;
    step(2);
    total++; if (paused !== 1'b1) begin bad++; $display("FAIL wrap_exit_paused got=%b exp=1", paused); end
    push(2);
    tick1();
    total++; if (disp !== 16'h0000) begin bad++; $display("FAIL wrap_result got=%h exp=0000", disp); end
  endtask
  task automatic test_pause();
    test_reset();
    push(2);
    for (int i = 0; i < 10; i++) tick1();
    push(100);
    total++; if (paused !== 1'b1) begin bad++; $display("FAIL pause_held got=%b exp=1", paused); end
    for (int i = 0; i < 5; i++) tick1();
    total++; if (disp !== 16'h0010) begin bad++; $display("FAIL pause_frozen got=%h exp=0010", disp); end
    push(3);
    total++; if (paused !== 1'b0) begin bad++; $display("FAIL pause_resume got=%b exp=0", paused); end
    tick1();
    total++; if (disp !== 16'h0011) begin bad++; $display("FAIL pause_next got=%h exp=0011", disp); end
  endtask
  task automatic test_adjust();
    test_reset();
    adj = 1'b1; sel = 1'b1;
    step(1);
    for (int i = 0; i < 61; i++) begin
      tick2();
      if (i % 8 == 0) tick1();
    end
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL adj_blink61 got=%b exp=1", blink); end
    tick2();
    total++; if (disp !== 16'h0002) begin bad++; $display("FAIL adj_sec62 got=%h exp=0002", disp); end
    total++; if (blink !== 1'b0) begin bad++; $display("FAIL adj_blink62 got=%b exp=0", blink); end
    sel = 1'b0;
    for (int i = 0; i < 3; i++) tick2();
    tick1();
    total++; if (disp !== 16'h0302) begin bad++; $display("FAIL adj_min3 got=%h exp=0302", disp); end
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL adj_blink65 got=%b exp=1", blink); end
    adj = 1'b0;
    step(2);
    total++; if (blink !== 1'b0) begin bad++; $display("FAIL adj_exit_blink got=%b exp=0", blink); end
    total++; if (paused !== 1'b1) begin bad++; $display("FAIL adj_exit_paused got=%b exp=1", paused); end
  endtask
  task automatic test_adj_run();
    test_reset();
    push(2);
    tick1();
    adj = 1'b1; sel = 1'b0;
    step(1);
    tick2();
    push(3);
    tick1();
    total++; if (disp !== 16'h0101) begin bad++; $display("FAIL adjrun_disp got=%h exp=0101", disp); end
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL adjrun_blink got=%b exp=1", blink); end
    adj = 1'b0;
    step(1);
    total++; if (blink !== 1'b0) begin bad++; $display("FAIL adjrun_exit_blink got=%b exp=0", blink); end
    total++; if (paused !== 1'b0) begin bad++; $display("FAIL adjrun_paused got=%b exp=0", paused); end
    tick1();
    total++; if (disp !== 16'h0102) begin bad++; $display("FAIL adjrun_resume got=%h exp=0102", disp); end
  endtask
  task automatic test_back_to_back();
    test_reset();
    push(2);
    btn_pause = 1'b1; clk_1hz = 1'b1;
    step(1);
    total++; if (disp !== 16'h0001) begin bad++; $display("FAIL b2b_run_disp got=%h exp=0001", disp); end
    total++; if (paused !== 1'b1) begin bad++; $display("FAIL b2b_run_paused got=%b exp=1", paused); end
    btn_pause = 1'b0; clk_1hz = 1'b0;
    step(2);
    btn_pause = 1'b1; clk_1hz = 1'b1;
    step(1);
    total++; if (disp !== 16'h0001) begin bad++; $display("FAIL b2b_pause_disp got=%h exp=0001", disp); end
    total++; if (paused !== 1'b0) begin bad++; $display("FAIL b2b_pause_paused got=%b exp=0", paused); end
    btn_pause = 1'b0; clk_1hz = 1'b0;
    step(2);
    tick1();
    total++; if (disp !== 16'h0002) begin bad++; $display("FAIL b2b_next got=%h exp=0002", disp); end
  endtask
  task automatic test_reset_mid();
    test_reset();
    adj = 1'b1; sel = 1'b0;
    step(1);
    for (int i = 0; i < 12; i++) tick2();
    sel = 1'b1;
    for (int i = 0; i < 34; i++) tick2();
    adj = 1'b0;
    step(1);
    push(2);
    total++; if (disp !== 16'h1234) begin bad++; $display("FAIL mid_preload got=%h exp=1234", disp); end
    clk_1hz = 1'b1; rst = 1'b1;
    step(1);
    total++; if (disp !== 16'h0000) begin bad++; $display("FAIL mid_cleared got=%h exp=0000", disp); end
    total++; if (paused !== 1'b1) begin bad++; $display("FAIL mid_paused got=%b exp=1", paused); end
    rst = 1'b0;
    step(1);
    push(2);
    step(5);
    total++; if (disp !== 16'h0000) begin bad++; $display("FAIL mid_no_tick got=%h exp=0000", disp); end
    clk_1hz = 1'b0;
    step(1);
    tick1();
    total++; if (disp !== 16'h0001) begin bad++; $display("FAIL mid_fresh got=%h exp=0001", disp); end
  endtask
  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_pause();
    test_adjust();
    test_adj_run();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Timekeeping core of the stopwatch. It sits directly downstream of the clock divider and consumes its 1 Hz and 2 Hz square-wave outputs as tick sources. It maintains an MM:SS count in four BCD digits, with run/pause control and a manual adjust mode. Its digit outputs feed the 7-segment display multiplexer, which runs off the divider's 400 Hz output.

Parameters:
MAX_MIN, 59, highest minutes value before wrap (≤ 99; tens digit = MAX_MIN/10)

Ports:
sclk       input   1  system clock; all logic on posedge
rst        input   1  synchronous, active-high reset
clk_1hz    input   1  1 Hz square wave from divider, synchronous to sclk
clk_2hz    input   1  2 Hz square wave from divider, synchronous to sclk
btn_pause  input   1  debounced pause button level; each rising edge toggles run/pause
adj        input   1  level; 1 = adjust mode
sel        input   1  adjust field select: 0 = minutes, 1 = seconds
min_tens   output  4  BCD minutes tens
min_ones   output  4  BCD minutes ones
sec_tens   output  4  BCD seconds tens (0..5)
sec_ones   output  4  BCD seconds ones
paused     output  1  1 when run flag is cleared
blink      output  1  adjust-mode blink phase for the display; 0 outside adjust

Behaviour:
- Reset (rst=1 at posedge):
  - all digits are 0, so the display reads 00:00.
  - paused=1, blink=0, FSM state is PAUSED.
  - prev_1hz, prev_2hz and prev_btn reset to 1, so no spurious tick or toggle occurs at reset release.
  - Reset overrides every other input in the same cycle, and reset mid-count clears the count immediately.
- Edge detect:
  - prev_x <= x every cycle.
  - tick_1hz = clk_1hz & ~prev_1hz; tick_2hz = clk_2hz & ~prev_2hz; press = btn_pause & ~prev_btn.
  - Each is a single-sclk-cycle pulse per rising edge. A held button produces exactly one press.
- FSM states:
  - RUN → PAUSED on press while adj=0.
  - PAUSED → RUN on press while adj=0.
  - RUN or PAUSED → ADJUST when adj=1. The run flag is stored on entry.
  - ADJUST → the stored RUN or PAUSED state when adj=0.
  - press is ignored while in ADJUST.
  - paused = ~run_flag, valid in all states.
- RUN counting, on tick_1hz:
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 carries into minutes.
  - minutes increment in BCD; at MAX_MIN (59:59 with default) the count wraps to 00:00.
  - Ticks in PAUSED or ADJUST are dropped and not accumulated.
- ADJUST, on tick_2hz:
  - The selected field increments by 1 in BCD.
  - seconds 59→00 and minutes MAX_MIN→00, with no carry between fields.
  - tick_1hz has no effect.
  - blink toggles on each tick_2hz while in ADJUST. It is forced to 0 on the first cycle out of ADJUST.
- Latency:
  - Digits, paused and blink update on the same posedge at which the source pulse is high.
  - That is one sclk edge after the input's 0→1 transition.
  - The FSM transition to ADJUST takes effect at the edge where adj is first sampled 1. A tick in that same cycle is evaluated against the old state.
- Simultaneous press and tick_1hz in RUN:
  - The tick is counted (decision uses the current state).
  - The state changes to PAUSED at the same edge.
- Simultaneous press and tick_1hz in PAUSED: no count; the state becomes RUN.
- Digits never hold a non-BCD value (>9, or sec_tens >5). Out-of-range values are unreachable from reset.

Test Plan:
- Reset, press once, apply 75 clk_1hz rising edges → display reads 01:15, paused=0; 1 extra sclk cycle of latency after each edge.
- Preload via 59 seconds plus MAX_MIN minutes in adjust, exit adjust, run 1 tick → wraps to 00:00 with no X/non-BCD digit.
- Running at 00:10, press (held 100 cycles) → paused=1 with a single toggle; 5 ticks leave 00:10; second press resumes, next tick → 00:11.
- adj=1, sel=1, 62 clk_2hz edges from 00:00 → 00:02 (minutes untouched), blink toggles 62 times; sel=0, 3 edges → 03:02; clk_1hz edges ignored throughout.
- Enter adjust while RUN, press during adjust, exit → resumes RUN (press ignored), blink=0.
- Assert rst mid-run at 12:34 with clk_1hz high → next cycle 00:00, paused=1; holding clk_1hz high after release produces no tick until a fresh 0→1.
